// File: rtl/mips_cpu_mem_arbiter_pkg.sv
// Shared types for the Harvard-core memory arbiter: step-sequencer states and
// the fixed byte-lane mask presented to the unified memory.
package mips_cpu_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      DATA,
      COMMIT,
      HALT
   } arb_state_t;

   localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_wait_watchdog.sv
// Saturating count of consecutive wait-state cycles; flags expiry on the
// cycle whose wait would bring the count up to WAIT_LIMIT.
module mips_cpu_wait_watchdog #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int unsigned   CNT_W   = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LIM_M1  = (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds waits already seen, so this cycle's wait is number r_cnt+1.
   assign expired = (WAIT_LIMIT != 0) && enable && (r_cnt >= LIM_M1);

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Multiplexes the core's instruction and data ports onto one wait-stated
// memory, one CPU step at a time, and pulses cpu_clk_enable to commit.
module mips_cpu_mem_arbiter #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_active,
   input  logic [31:0] cpu_instr_address,
   output logic [31:0] cpu_instr_readdata,
   input  logic [31:0] cpu_data_address,
   input  logic        cpu_data_read,
   input  logic        cpu_data_write,
   input  logic [31:0] cpu_data_writedata,
   output logic [31:0] cpu_data_readdata,
   output logic        cpu_clk_enable,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic        halted,
   output logic        error
);

   import mips_cpu_mem_arbiter_pkg::*;

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic [31:0] r_instr;
   logic [31:0] r_dread;
   logic        r_error;
   logic        w_set_error;
   logic        w_req;
   logic        w_wait;
   logic        w_accept;
   logic        w_clear;
   logic        w_expired;

   // Strobes are gated by reset so they drop the instant reset asserts.
   assign mem_read  = reset && (((r_state == FETCH) && cpu_active) ||
                                ((r_state == DATA) && cpu_data_read));
   assign mem_write = reset && (r_state == DATA) && cpu_data_write;
   assign mem_address    = (r_state == DATA) ? cpu_data_address : cpu_instr_address;
   assign mem_writedata  = (r_state == DATA) ? cpu_data_writedata : '0;
   assign mem_byteenable = BYTEEN_ALL;

   assign w_req    = mem_read || mem_write;
   assign w_wait   = w_req && mem_waitrequest;
   assign w_accept = w_req && !mem_waitrequest;
   assign w_clear  = !w_wait;

   mips_cpu_wait_watchdog #(
      .WAIT_LIMIT (WAIT_LIMIT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .enable  (w_wait),
      .clear   (w_clear),
      .expired (w_expired)
   );

   always_comb begin
      w_next      = r_state;
      w_set_error = 1'b0;
      case (r_state)
         FETCH: begin
            if (!cpu_active) begin
               w_next = HALT;
            end else if (w_accept) begin
               w_next = DECODE;
            end else if (w_expired) begin
               w_next      = HALT;
               w_set_error = 1'b1;
            end
         end
         DECODE: begin
            if (cpu_data_read && cpu_data_write) begin
               w_next      = HALT;
               w_set_error = 1'b1;
            end else if (cpu_data_read || cpu_data_write) begin
               w_next = DATA;
            end else begin
               w_next = COMMIT;
            end
         end
         DATA: begin
            // A core that withdraws its request mid-access would otherwise stall forever.
            if (!w_req) begin
               w_next      = HALT;
               w_set_error = 1'b1;
            end else if (w_accept) begin
               w_next = COMMIT;
            end else if (w_expired) begin
               w_next      = HALT;
               w_set_error = 1'b1;
            end
         end
         COMMIT:  w_next = FETCH;
         HALT:    w_next = HALT;
         default: w_next = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
         r_instr <= '0;
         r_dread <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_error) begin
            r_error <= 1'b1;
         end
         if ((r_state == FETCH) && w_accept) begin
            r_instr <= mem_readdata;
         end
         if ((r_state == DATA) && w_accept && cpu_data_read) begin
            r_dread <= mem_readdata;
         end
      end
   end

   assign cpu_instr_readdata = r_instr;
   assign cpu_data_readdata  = r_dread;
   assign cpu_clk_enable     = reset && (r_state == COMMIT);
   assign halted             = (r_state == HALT);
   assign error              = r_error;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: the bench plays both core and memory,
// with per-step expectations queued at drive time and checked at commit.
module tb_mips_cpu_mem_arbiter;

   localparam int unsigned WL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_active;
   logic [31:0] cpu_instr_address;
   logic [31:0] cpu_instr_readdata;
   logic [31:0] cpu_data_address;
   logic        cpu_data_read;
   logic        cpu_data_write;
   logic [31:0] cpu_data_writedata;
   logic [31:0] cpu_data_readdata;
   logic        cpu_clk_enable;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        halted;
   logic        error;

   mips_cpu_mem_arbiter #(.WAIT_LIMIT(WL)) dut (
      .clk                (clk),
      .reset              (reset),
      .cpu_active         (cpu_active),
      .cpu_instr_address  (cpu_instr_address),
      .cpu_instr_readdata (cpu_instr_readdata),
      .cpu_data_address   (cpu_data_address),
      .cpu_data_read      (cpu_data_read),
      .cpu_data_write     (cpu_data_write),
      .cpu_data_writedata (cpu_data_writedata),
      .cpu_data_readdata  (cpu_data_readdata),
      .cpu_clk_enable     (cpu_clk_enable),
      .mem_address        (mem_address),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .mem_writedata      (mem_writedata),
      .mem_byteenable     (mem_byteenable),
      .mem_waitrequest    (mem_waitrequest),
      .mem_readdata       (mem_readdata),
      .halted             (halted),
      .error              (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        ld;
      logic        st;
      int          wf;
      int          wd;
   } vec_t;

   typedef struct {
      int          cycles;
      int          reads;
      int          writes;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] dread;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic        ld;
      logic        st;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[7];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_dread = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Runs one CPU step starting at the beginning of a FETCH cycle (posedge+1).
   task automatic run_step(input vec_t v, input bit drop_at_commit);
      exp_t        e;
      exp_t        got;
      bit          fetched = 1'b0;
      bit          done = 1'b0;
      int          left;
      int          reads = 0;
      int          writes = 0;
      int          waccs = 0;
      int          ncyc = 0;
      logic [31:0] faddr = '1;
      logic [31:0] daddr_seen = '1;
      logic [31:0] wdata_seen = '1;

      e.cycles = 3 + ((v.ld || v.st) ? 1 : 0) + v.wf + v.wd;
      e.reads  = 1 + v.wf + (v.ld ? 1 + v.wd : 0);
      e.writes = v.st ? 1 + v.wd : 0;
      e.pc     = v.pc;
      e.instr  = v.instr;
      e.dread  = v.ld ? v.rdata : last_dread;
      e.daddr  = v.daddr;
      e.wdata  = v.wdata;
      e.ld     = v.ld;
      e.st     = v.st;
      sb.push_back(e);
      last_dread = e.dread;

      cpu_instr_address  = v.pc;
      cpu_data_address   = v.daddr;
      cpu_data_read      = v.ld;
      cpu_data_write     = v.st;
      cpu_data_writedata = v.wdata;
      left = v.wf;
      #1;

      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         if (mem_read || mem_write) begin
            mem_waitrequest = (left > 0);
            mem_readdata    = (left > 0) ? (32'hBAD0_0000 | cyc) : (fetched ? v.rdata : v.instr);
         end else begin
            mem_waitrequest = 1'b0;
            mem_readdata    = 32'h5A5A_0000 | cyc;
         end
         #1;
         if (mem_read)  reads++;
         if (mem_write) writes++;
         if ((mem_read || mem_write) && !mem_waitrequest) begin
            if (!fetched) begin
               faddr   = mem_address;
               fetched = 1'b1;
               left    = v.wd;
            end else begin
               daddr_seen = mem_address;
               if (mem_write) begin
                  waccs++;
                  wdata_seen = mem_writedata;
               end
            end
         end else if (mem_read || mem_write) begin
            left--;
         end
         if (cpu_clk_enable) begin
            done = 1'b1;
            ncyc = cyc;
            if (drop_at_commit) cpu_active = 1'b0;
         end
         @(posedge clk);
         #1;
      end

      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL step_timeout: no commit within 40 cycles, pc %h", v.pc);
      end
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk("commit_cycle", ncyc, got.cycles);
         chk("instr_latch", cpu_instr_readdata, got.instr);
         chk("data_latch", cpu_data_readdata, got.dread);
         chk("fetch_addr", faddr, got.pc);
         chk("read_cycles", reads, got.reads);
         chk("write_cycles", writes, got.writes);
         chk("write_accepts", waccs, got.st ? 1 : 0);
         if (got.ld || got.st) chk("data_addr", daddr_seen, got.daddr);
         if (got.st) chk("write_data", wdata_seen, got.wdata);
         chk("byteenable", {28'd0, mem_byteenable}, 32'hF);
         chk1("no_error", error, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      reset              = 1'b0;
      cpu_active         = 1'b1;
      cpu_instr_address  = 32'hBFC0_0000;
      cpu_data_address   = '0;
      cpu_data_read      = 1'b0;
      cpu_data_write     = 1'b0;
      cpu_data_writedata = '0;
      mem_waitrequest    = 1'b0;
      mem_readdata       = '0;

      vecs[0] = '{32'hBFC0_0000, 32'h2402_0005, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 0, 0};
      vecs[1] = '{32'hBFC0_0004, 32'h2402_0005, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 0, 0};
      vecs[2] = '{32'hBFC0_0000, 32'h8C43_0000, 32'h0000_0100, 32'h0,     32'hDEAD_BEEF, 1'b1, 1'b0, 0, 2};
      vecs[3] = '{32'hBFC0_0008, 32'hAC43_0000, 32'h0000_1000, 32'h1234_5678, 32'h7777_7777, 1'b0, 1'b1, 0, 0};
      vecs[4] = '{32'hBFC0_000C, 32'h8C44_0004, 32'h0000_2004, 32'h0,     32'hCAFE_F00D, 1'b1, 1'b0, 3, 3};
      vecs[5] = '{32'hBFC0_0010, 32'hAC45_0008, 32'h0000_2008, 32'hA5A5_5A5A, 32'h1111_1111, 1'b0, 1'b1, 1, 2};
      vecs[6] = '{32'hBFC0_0014, 32'h0000_0000, 32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 2, 0};

      #12;
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_clk_enable", cpu_clk_enable, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_error", error, 1'b0);
      chk("rst_instr", cpu_instr_readdata, 32'h0);
      chk("rst_dread", cpu_data_readdata, 32'h0);

      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 7; i++) run_step(vecs[i], 1'b0);

      // cpu_active falls during COMMIT: the following FETCH must not request.
      run_step(vecs[0], 1'b1);
      chk1("drop_fetch_no_read", mem_read, 1'b0);
      @(posedge clk);
      #1;
      chk1("drop_halted", halted, 1'b1);
      chk1("drop_no_error", error, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk1("drop_halt_no_read", mem_read, 1'b0);

      // Reset asserted while a store is waiting in DATA.
      reset              = 1'b0;
      cpu_active         = 1'b1;
      cpu_instr_address  = 32'hBFC0_0020;
      cpu_data_address   = 32'h0000_3000;
      cpu_data_read      = 1'b0;
      cpu_data_write     = 1'b1;
      cpu_data_writedata = 32'h0BAD_CAFE;
      mem_waitrequest    = 1'b0;
      mem_readdata       = 32'hAC46_0000;
      #1;
      reset = 1'b1;
      #1;
      chk1("release_first_read", mem_read, 1'b1);
      chk("release_fetch_addr", mem_address, 32'hBFC0_0020);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      mem_waitrequest = 1'b1;
      #1;
      chk1("mid_data_write_up", mem_write, 1'b1);
      chk("mid_data_addr", mem_address, 32'h0000_3000);
      reset = 1'b0;
      #1;
      chk1("mid_data_rst_write", mem_write, 1'b0);
      chk1("mid_data_rst_read", mem_read, 1'b0);
      chk("mid_data_rst_instr", cpu_instr_readdata, 32'h0);
      @(posedge clk);
      #1;
      mem_waitrequest = 1'b0;
      reset = 1'b1;
      #1;
      chk1("rerelease_read", mem_read, 1'b1);
      chk1("rerelease_no_write", mem_write, 1'b0);
      chk("rerelease_addr", mem_address, 32'hBFC0_0020);

      // Load and store requested together is illegal.
      cpu_data_read = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk1("illegal_halted", halted, 1'b1);
      chk1("illegal_error", error, 1'b1);
      chk1("illegal_no_read", mem_read, 1'b0);
      chk1("illegal_no_write", mem_write, 1'b0);

      // Watchdog: waitrequest stuck high during FETCH.
      reset           = 1'b0;
      cpu_data_read   = 1'b0;
      cpu_data_write  = 1'b0;
      mem_waitrequest = 1'b1;
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk1("wd_before_halted", halted, 1'b0);
      chk1("wd_before_error", error, 1'b0);
      chk1("wd_before_read", mem_read, 1'b1);
      @(posedge clk);
      #1;
      chk1("wd_halted", halted, 1'b1);
      chk1("wd_error", error, 1'b1);
      chk1("wd_no_read", mem_read, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk1("wd_still_no_read", mem_read, 1'b0);
      chk1("wd_no_commit", cpu_clk_enable, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

- Shares one single-port, wait-stated memory between the Harvard core's instruction and data ports.
- Sequences each CPU step as instruction fetch, optional data access, then a one-cycle `clk_enable` commit pulse.
- Sits between `mips_cpu_harvard` and a unified RAM/bus model.
- Owns stall generation, a wait-state watchdog and halt detection.

## Interface
Parameters:
- `WAIT_LIMIT`, 255: consecutive `mem_waitrequest` cycles tolerated per access; 0 disables the watchdog.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `cpu_active` in 1: core's `active` output.
- `cpu_instr_address` in 32: core fetch address.
- `cpu_instr_readdata` out 32: latched instruction word to core.
- `cpu_data_address` in 32: core data address.
- `cpu_data_read` in 1: core load request.
- `cpu_data_write` in 1: core store request.
- `cpu_data_writedata` in 32: core store data.
- `cpu_data_readdata` out 32: latched load data to core.
- `cpu_clk_enable` out 1: commit pulse to core `clk_enable`.
- `mem_address` out 32: memory address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_writedata` out 32: memory write data.
- `mem_byteenable` out 4: byte lanes; constant 4'hF.
- `mem_waitrequest` in 1: memory stall; high = request not accepted this cycle.
- `mem_readdata` in 32: memory read data, valid on the accepting cycle.
- `halted` out 1: sticky; arbiter stopped.
- `error` out 1: sticky; watchdog expiry or illegal request.

## Operation
FSM states:
- FETCH
  - If `cpu_active`=0: go to HALT, no request issued.
  - Else drive `mem_read`=1, `mem_address`=`cpu_instr_address`.
  - On a cycle with `mem_waitrequest`=0: latch `mem_readdata` into `cpu_instr_readdata`, go to DECODE.
- DECODE (one cycle): core settles on the latched instruction; sample `cpu_data_read` and `cpu_data_write`.
  - Both 1: set `error`, go to HALT.
  - Either 1: go to DATA.
  - Neither: go to COMMIT.
- DATA
  - Drive `mem_address`=`cpu_data_address`.
  - Drive `mem_read`=`cpu_data_read`, `mem_write`=`cpu_data_write`, `mem_writedata`=`cpu_data_writedata`.
  - On `mem_waitrequest`=0: latch `mem_readdata` into `cpu_data_readdata` if read; go to COMMIT.
- COMMIT: `cpu_clk_enable`=1 for exactly this cycle, then FETCH.
  - The store already happened in DATA; the core's `data_write` during COMMIT is not forwarded to memory.
- HALT: absorbing until reset.
  - `halted`=1; all `mem_*` strobes and `cpu_clk_enable` are 0.

Rules:
- `mem_read`, `mem_write` and `cpu_clk_enable` are 0 in every state other than those listed above.
- `mem_*` outputs are combinational from the state register and the stable core inputs.
- Watchdog:
  - `wait_cnt` increments each FETCH/DATA cycle with `mem_waitrequest`=1, and clears on acceptance or state change.
  - When `WAIT_LIMIT`≠0 and `wait_cnt` reaches `WAIT_LIMIT` while still waiting: set `error`, go to HALT, drop strobes.
  - The counter saturates and never wraps.

## Timing
- Reset values:
  - state = FETCH.
  - `cpu_instr_readdata`, `cpu_data_readdata` = 0.
  - `halted`, `error`, `cpu_clk_enable`, `mem_read`, `mem_write` = 0.
  - `wait_cnt` = 0.
- First `mem_read` is visible in the first cycle after reset deasserts, provided `cpu_active`=1.
- Zero-wait step latency:
  - 3 cycles with no data access (FETCH, DECODE, COMMIT).
  - 4 cycles with a data access.
- Each `mem_waitrequest` cycle adds one cycle.
- The latched readdata registers update only on the accepting cycle and hold otherwise.
- Reset asserted mid-access: strobes fall asynchronously and state returns to FETCH. Completion of an interrupted write is undefined at memory.
- `cpu_active` is sampled only in FETCH; a fall in any other state takes effect at the next FETCH.
- `mem_waitrequest` falling on the same cycle the watchdog limit is hit counts as acceptance; no error.

## Structure
- Package `mips_cpu_mem_arbiter_pkg`:
  - typedef `arb_state_t` with FETCH, DECODE, DATA, COMMIT, HALT.
  - constant `BYTEEN_ALL`=4'hF.
- Sub-module `mips_cpu_wait_watchdog`:
  - Saturating counter plus limit compare.
  - Inputs: clk, reset, enable, clear. Output: expired.

## Test plan
- Zero-wait memory, instruction 0x24020005 (addiu $v0,$zero,5) at 0xBFC00000 -> `cpu_clk_enable` pulses every 3rd cycle; `mem_read` only in FETCH.
- `lw` at 0xBFC00000, `mem_waitrequest` high 2 cycles in DATA, readdata 0xDEADBEEF -> `cpu_data_readdata`=0xDEADBEEF; commit on cycle 6 after FETCH start.
- `sw` of 0x12345678 to 0x1000 -> exactly one accepted `mem_write` cycle with that data and address, `mem_byteenable`=4'hF, and no write during COMMIT.
- `WAIT_LIMIT`=4 with `mem_waitrequest` stuck high in FETCH -> `error`=1 and `halted`=1 after the 4th wait cycle; strobes 0 thereafter.
- `cpu_active` dropped at COMMIT -> next state HALT with no further `mem_read`; `reset` low mid-DATA -> strobes 0 same cycle, FETCH on release.
